// File: rtl/rv32_multicycle_core_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcode/funct codes,
// FSM state and trap encodings, ALU control codes and the ALU itself.
package rv32_multicycle_core_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    TRAP_NONE, TRAP_ILLEGAL, TRAP_MISALIGN, TRAP_SYSTEM
  } trap_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  // Address generation for loads/stores/branches is always an add.
  function automatic alu_op_t alu_decode(input logic [6:0] opcode,
                                         input logic [2:0] f3,
                                         input logic f7_alt);
    alu_op_t op;
    op = ALU_ADD;
    if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
      case (f3)
        F3_ADD_SUB: op = (opcode == OPC_OP && f7_alt) ? ALU_SUB : ALU_ADD;
        F3_SLL:     op = ALU_SLL;
        F3_SLT:     op = ALU_SLT;
        F3_SLTU:    op = ALU_SLTU;
        F3_XOR:     op = ALU_XOR;
        F3_SR:      op = f7_alt ? ALU_SRA : ALU_SRL;
        F3_OR:      op = ALU_OR;
        default:    op = ALU_AND;
      endcase
    end
    return op;
  endfunction

  function automatic logic [XLEN-1:0] alu_exec(input alu_op_t op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [XLEN-1:0] res;
    a_s = a;
    b_s = b;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLL:  res = a << b[4:0];
      ALU_SRL:  res = a >> b[4:0];
      ALU_SRA:  res = a_s >>> b[4:0];
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      default:  res = {{(XLEN-1){1'b0}}, (a < b)};
    endcase
    return res;
  endfunction

  // SYSTEM is classified separately before this check is consulted.
  function automatic logic insn_legal(input logic [6:0] opcode,
                                      input logic [2:0] f3,
                                      input logic [6:0] f7);
    logic ok;
    case (opcode)
      OPC_OP:     ok = (f7 == F7_BASE) ||
                       (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SR));
      OPC_OP_IMM: begin
        if (f3 == F3_SLL)     ok = (f7 == F7_BASE);
        else if (f3 == F3_SR) ok = (f7 == F7_BASE) || (f7 == F7_ALT);
        else                  ok = 1'b1;
      end
      OPC_LOAD,
      OPC_STORE:  ok = (f3 == F3_WORD);
      OPC_BRANCH: ok = (f3 == F3_BEQ) || (f3 == F3_BNE);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rv32_mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, x0 hardwired to zero, all registers cleared by synchronous reset.
// Ports: clk, rst; rs1_addr/rs1_data, rs2_addr/rs2_data (reads);
//        we, rd_addr, rd_data (write).
module rv32_mc_regfile
  import rv32_multicycle_core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && rd_addr != 5'd0) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I subset core with a single request/ready memory port.
// Ports: clk, rst (sync, active-high); mem_req/mem_we/mem_addr/mem_wdata
// out and mem_rdata/mem_ready in form the unified memory port; retire
// pulses per committed instruction; pc_o is the architectural PC; halted
// and trap_cause report a sticky trap stop.
module rv32_multicycle_core
  import rv32_multicycle_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic [31:0]       pc_o,
  output logic              halted,
  output logic [1:0]        trap_cause
);

  state_t      state, state_nxt;
  trap_t       trap, trap_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] ir, a_reg, b_reg, imm_reg, alu_out, mdr;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_dec, rs1_data, rs2_data, alu_res, br_target, pc_plus4;
  logic [31:0] rf_wd;
  logic        rf_we, br_taken, req_c, we_c, retire_c, data_addr;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];

  always_comb begin
    case (opcode)
      OPC_STORE:  imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH: imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default:    imm_dec = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  rv32_mc_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (ir[19:15]),
    .rs2_addr (ir[24:20]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (rf_we),
    .rd_addr  (ir[11:7]),
    .rd_data  (rf_wd)
  );

  assign alu_res   = alu_exec(alu_decode(opcode, f3, f7[5]), a_reg,
                              (opcode == OPC_OP) ? b_reg : imm_reg);
  assign br_target = pc + imm_reg;
  assign br_taken  = (f3 == F3_BEQ) ? (a_reg == b_reg) : (a_reg != b_reg);
  assign pc_plus4  = pc + 32'd4;

  always_comb begin
    state_nxt = state;
    trap_nxt  = trap;
    pc_nxt    = pc;
    req_c     = 1'b0;
    we_c      = 1'b0;
    data_addr = 1'b0;
    retire_c  = 1'b0;
    rf_we     = 1'b0;
    rf_wd     = alu_out;
    case (state)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OPC_SYSTEM) begin
          state_nxt = S_HALT;
          trap_nxt  = TRAP_SYSTEM;
        end else if (!insn_legal(opcode, f3, f7)) begin
          state_nxt = S_HALT;
          trap_nxt  = TRAP_ILLEGAL;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: begin
            if (alu_res[1:0] != 2'b00) begin
              state_nxt = S_HALT;
              trap_nxt  = TRAP_MISALIGN;
            end else begin
              state_nxt = S_MEM;
            end
          end
          OPC_BRANCH: begin
            // Only a taken branch can fault; bit 0 of a B-immediate is 0.
            if (br_taken && br_target[1]) begin
              state_nxt = S_HALT;
              trap_nxt  = TRAP_MISALIGN;
            end else begin
              pc_nxt    = br_taken ? br_target : pc_plus4;
              retire_c  = 1'b1;
              state_nxt = S_FETCH;
            end
          end
          default: state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        req_c     = 1'b1;
        we_c      = (opcode == OPC_STORE);
        data_addr = 1'b1;
        if (mem_ready) begin
          if (opcode == OPC_STORE) begin
            pc_nxt    = pc_plus4;
            retire_c  = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        rf_wd     = (opcode == OPC_LOAD) ? mdr : alu_out;
        pc_nxt    = pc_plus4;
        retire_c  = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      trap  <= TRAP_NONE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      trap  <= trap_nxt;
      pc    <= pc_nxt;
    end
  end

  // Datapath latches carry no reset; each is written before it is consumed.
  always_ff @(posedge clk) begin
    if (state == S_FETCH && mem_ready) ir <= mem_rdata;
    if (state == S_DECODE) begin
      a_reg   <= rs1_data;
      b_reg   <= rs2_data;
      imm_reg <= imm_dec;
    end
    if (state == S_EXEC) alu_out <= alu_res;
    if (state == S_MEM && mem_ready) mdr <= mem_rdata;
  end

  // Gating with rst abandons an outstanding request as soon as reset is seen
  // and keeps all status outputs quiet throughout the reset cycle.
  assign mem_req    = req_c & ~rst;
  assign mem_we     = we_c;
  assign mem_addr   = data_addr ? alu_out[ADDR_W-1:0] : pc[ADDR_W-1:0];
  assign mem_wdata  = b_reg;
  assign retire     = retire_c & ~rst;
  assign pc_o       = pc;
  assign halted     = (state == S_HALT) & ~rst;
  assign trap_cause = rst ? TRAP_NONE : trap;

endmodule

// File: tb/tb_rv32_multicycle_core.sv
module tb_rv32_multicycle_core;

  logic        clk;
  logic        rst;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;
  logic [1:0]  trap_cause;

  rv32_multicycle_core #(.RESET_PC(32'h100), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .retire     (retire),
    .pc_o       (pc_o),
    .halted     (halted),
    .trap_cause (trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] prog [256];
  logic [31:0] mem  [256];
  logic        load_mem = 1'b0;
  int          fetch_wait = 0;
  int          data_wait = 0;
  int          wcnt = 0;
  int          cur_wait;

  assign cur_wait  = (!mem_we && mem_addr == pc_o) ? fetch_wait : data_wait;
  // ready may be high while idle; the core must ignore it then
  assign mem_ready = (wcnt >= cur_wait);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
      wcnt <= 0;
    end else if (mem_req && mem_ready) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      wcnt <= 0;
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [31:0] pc; int cyc; } ret_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  ret_t rexp[$];
  wr_t  wexp[$];

  task automatic push_ret(input logic [31:0] pc, input int cyc);
    ret_t r;
    r.pc = pc; r.cyc = cyc;
    rexp.push_back(r);
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr; w.data = data;
    wexp.push_back(w);
  endtask

  int          cyc = 0, last_ret = 0, acc = 0;
  logic        pc_pend = 1'b0;
  logic [31:0] pc_want;

  initial begin
    ret_t r;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; last_ret = 0; acc = 0; pc_pend = 1'b0;
      end else begin
        cyc++;
        if (pc_pend) begin
          check_eq("pc_after_retire", pc_o, pc_want);
          pc_pend = 1'b0;
        end
        if (retire) begin
          check_eq("retire_expected", rexp.size() != 0, 1);
          if (rexp.size() != 0) begin
            r = rexp.pop_front();
            check_eq("insn_cycles", cyc - last_ret, r.cyc);
            pc_want = r.pc;
            pc_pend = 1'b1;
          end
          last_ret = cyc;
        end
        if (mem_req && mem_ready) begin
          acc++;
          if (mem_we) begin
            check_eq("write_expected", wexp.size() != 0, 1);
            if (wexp.size() != 0) begin
              w = wexp.pop_front();
              check_eq("write_addr", mem_addr, w.addr);
              check_eq("write_data", mem_wdata, w.data);
            end
          end
        end
      end
    end
  end

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    logic [31:0] v, a, f, d;
    v = imm; a = rs1; f = f3; d = rd;
    return {v[11:0], a[4:0], f[2:0], d[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    logic [31:0] b, a, f, d;
    b = rs2; a = rs1; f = f3; d = rd;
    return {f7, b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] v, b, a;
    v = imm; b = rs2; a = rs1;
    return {v[11:5], b[4:0], a[4:0], 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v, b, a, f;
    v = imm; b = rs2; a = rs1; f = f3;
    return {v[12], v[10:5], b[4:0], a[4:0], f[2:0], v[4:1], v[11], 7'b1100011};
  endfunction

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, OPI);
  endfunction

  function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 2, rd, 7'b0000011);
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] insn);
    prog[addr[9:2]] = insn;
  endtask

  // ---------------- sequencing ----------------
  task automatic do_reset();
    rst = 1'b1;
    load_mem = 1'b1;
    @(posedge clk);
    #1 load_mem = 1'b0;
    @(negedge clk);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_retire", retire, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_trap", trap_cause, 0);
    check_eq("rst_pc", pc_o, 32'h100);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_to_halt(input logic [1:0] cause, input logic [31:0] pc);
    int n;
    n = 0;
    while (!halted && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    @(negedge clk); #1;
    check_eq("halted", halted, 1);
    check_eq("trap_cause", trap_cause, cause);
    check_eq("halt_pc", pc_o, pc);
    check_eq("retires_left", rexp.size(), 0);
    check_eq("writes_left", wexp.size(), 0);
    rexp.delete();
    wexp.delete();
  endtask

  initial begin
    int n, acc_h;
    rst = 1'b1;

    // arithmetic chain, zero-wait memory
    clear_prog(); fetch_wait = 0; data_wait = 0;
    put(32'h100, addi(1, 0, 5));
    put(32'h104, addi(2, 0, -3));
    put(32'h108, enc_r(7'h00, 2, 1, 0, 3));
    put(32'h10C, enc_s(64, 3, 0));
    put(32'h110, ECALL);
    push_ret(32'h104, 4); push_ret(32'h108, 4); push_ret(32'h10C, 4); push_ret(32'h110, 4);
    push_wr(64, 2);
    do_reset();
    run_to_halt(2'd3, 32'h110);

    // store then load with 2 data wait states
    clear_prog(); fetch_wait = 0; data_wait = 2;
    put(32'h100, addi(3, 0, 2));
    put(32'h104, enc_s(8, 3, 0));
    put(32'h108, lw(4, 0, 8));
    put(32'h10C, enc_s(68, 4, 0));
    put(32'h110, ECALL);
    push_ret(32'h104, 4); push_ret(32'h108, 6); push_ret(32'h10C, 7); push_ret(32'h110, 6);
    push_wr(8, 2); push_wr(68, 2);
    do_reset();
    run_to_halt(2'd3, 32'h110);

    // branches: taken forward, taken backward, not taken
    clear_prog(); fetch_wait = 0; data_wait = 0;
    put(32'h100, addi(1, 0, 1));
    put(32'h104, enc_b(12, 0, 0, 0));
    put(32'h108, enc_b(100, 0, 1, 0));
    put(32'h10C, ECALL);
    put(32'h110, enc_b(-8, 0, 1, 1));
    push_ret(32'h104, 4); push_ret(32'h110, 3); push_ret(32'h108, 3); push_ret(32'h10C, 3);
    do_reset();
    run_to_halt(2'd3, 32'h10C);

    // misaligned load: no data access, sticky halt
    clear_prog();
    put(32'h100, addi(5, 0, 2));
    put(32'h104, lw(6, 5, 0));
    push_ret(32'h104, 4);
    do_reset();
    run_to_halt(2'd2, 32'h104);
    check_eq("misaligned_accesses", acc, 2);
    acc_h = acc;
    repeat (5) @(negedge clk);
    #1;
    check_eq("halt_sticky", halted, 1);
    check_eq("halt_no_req", acc, acc_h);
    check_eq("halt_pc_frozen", pc_o, 32'h104);

    // misaligned branch target only faults when taken
    clear_prog();
    put(32'h100, enc_b(6, 0, 0, 1));
    put(32'h104, enc_b(6, 0, 0, 0));
    push_ret(32'h104, 3);
    do_reset();
    run_to_halt(2'd2, 32'h104);

    // illegal opcode and illegal funct7
    clear_prog();
    put(32'h100, 32'h0000_007F);
    do_reset();
    run_to_halt(2'd1, 32'h100);
    clear_prog();
    put(32'h100, enc_r(7'h01, 2, 1, 0, 3));
    do_reset();
    run_to_halt(2'd1, 32'h100);

    // x0 write discard, shifts, compares, xor
    clear_prog();
    put(32'h100, addi(0, 0, 7));
    put(32'h104, enc_s(16, 0, 0));
    put(32'h108, addi(1, 0, 1));
    put(32'h10C, enc_i(31, 1, 1, 1, OPI));
    put(32'h110, enc_i(32'h404, 1, 5, 2, OPI));
    put(32'h114, enc_s(20, 2, 0));
    put(32'h118, enc_i(4, 1, 5, 3, OPI));
    put(32'h11C, enc_s(24, 3, 0));
    put(32'h120, addi(4, 0, -1));
    put(32'h124, enc_r(7'h00, 4, 0, 3, 5));
    put(32'h128, enc_r(7'h00, 0, 4, 2, 6));
    put(32'h12C, enc_r(7'h00, 1, 4, 4, 7));
    put(32'h130, enc_s(28, 5, 0));
    put(32'h134, enc_s(32, 6, 0));
    put(32'h138, enc_s(36, 7, 0));
    put(32'h13C, addi(9, 0, 36));
    put(32'h140, enc_r(7'h20, 9, 1, 5, 8));
    put(32'h144, enc_s(40, 8, 0));
    put(32'h148, ECALL);
    for (int i = 1; i <= 18; i++) push_ret(32'h100 + 32'(4 * i), 4);
    push_wr(16, 32'h0); push_wr(20, 32'hF800_0000); push_wr(24, 32'h0800_0000);
    push_wr(28, 32'h1); push_wr(32, 32'h1); push_wr(36, 32'h7FFF_FFFF);
    push_wr(40, 32'hF800_0000);
    do_reset();
    run_to_halt(2'd3, 32'h148);

    // reset during a stalled fetch
    clear_prog(); fetch_wait = 0;
    put(32'h100, enc_s(32, 7, 0));
    put(32'h104, addi(7, 0, 9));
    put(32'h108, ECALL);
    push_ret(32'h104, 4); push_ret(32'h108, 4);
    push_wr(32, 32'h0);
    do_reset();
    n = 0;
    while (rexp.size() != 0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("stall_prefix_retired", rexp.size(), 0);
    fetch_wait = 1000;
    repeat (3) @(negedge clk);
    #1;
    check_eq("stall_req_held", mem_req, 1);
    check_eq("stall_addr", mem_addr, 32'h108);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_req_drop", mem_req, 0);
    check_eq("abort_pc", pc_o, 32'h100);
    fetch_wait = 0;
    push_ret(32'h104, 4); push_ret(32'h108, 4);
    push_wr(32, 32'h0);
    do_reset();
    run_to_halt(2'd3, 32'h108);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
